mul_div_sequencer: RTL and testbench

//   Multi-cycle integer multiply/divide unit beside the single-cycle ALU in EX.

---
 rtl/mul_div_sequencer.sv | 148 ++++++++++++++
 tb/tb_mul_div_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_sequencer.sv
// mul_div_sequencer: multi-cycle radix-2 multiply/divide unit.
// Signed operations run on magnitudes. The sign fix is applied on the last
// iteration edge, so hi/lo and done are registered and valid during FIX.
module mul_div_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DIVZ = 2'd3
    } state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic             is_div;
    logic             neg_q;      // product or quotient gets negated
    logic             neg_r;      // remainder gets negated (dividend sign)
    logic [WIDTH-1:0] acc;        // product upper half / partial remainder
    logic [WIDTH-1:0] q;          // multiplier bits / dividend-quotient bits
    logic [WIDTH-1:0] opnd;       // multiplicand or divisor magnitude

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    logic [WIDTH:0]     mult_sum;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff;
    logic [WIDTH-1:0]   iter_acc;
    logic [WIDTH-1:0]   iter_q;
    logic [2*WIDTH-1:0] prod_mag;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign busy = (state != IDLE);

    // Operand sign detection and magnitudes; the unsigned ops (op[0]=1) never negate
    always_comb begin
        a_neg = ~op[0] & src_a[WIDTH-1];
        b_neg = ~op[0] & src_b[WIDTH-1];
        a_mag = a_neg ? (~src_a + 1'b1) : src_a;
        b_mag = b_neg ? (~src_b + 1'b1) : src_b;
    end

    // One datapath iteration plus the sign-corrected final results
    always_comb begin
        mult_sum  = {1'b0, acc} + (q[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        div_shift = {acc, q[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opnd});
        // The true difference is below the divisor, so it fits in WIDTH bits
        div_diff  = div_shift[WIDTH-1:0] - opnd;
        if (is_div) begin
            iter_acc = div_ge ? div_diff : div_shift[WIDTH-1:0];
            iter_q   = {q[WIDTH-2:0], div_ge};
        end else begin
            iter_acc = mult_sum[WIDTH:1];
            iter_q   = {mult_sum[0], q[WIDTH-1:1]};
        end
        prod_mag = {iter_acc, iter_q};
        prod_fix = neg_q ? (~prod_mag + 1'b1) : prod_mag;
        quot_fix = neg_q ? (~iter_q + 1'b1) : iter_q;
        rem_fix  = neg_r ? (~iter_acc + 1'b1) : iter_acc;
    end

    // Control FSM with registered datapath state and outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            count  <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            acc    <= '0;
            q      <= '0;
            opnd   <= '0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !flush) begin
                        is_div <= op[1];
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                        acc    <= '0;
                        count  <= '0;
                        opnd   <= op[1] ? b_mag : a_mag;
                        q      <= op[1] ? a_mag : b_mag;
                        if (op[1] && (src_b == '0)) begin
                            state <= DIVZ;
                            lo    <= '1;
                            hi    <= src_a;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        acc   <= iter_acc;
                        q     <= iter_q;
                        count <= count + 1'b1;
                        if (count == CW'(WIDTH - 1)) begin
                            state <= FIX;
                            done  <= 1'b1;
                            if (is_div) begin
                                hi <= rem_fix;
                                lo <= quot_fix;
                            end else begin
                                hi <= prod_fix[2*WIDTH-1:WIDTH];
                                lo <= prod_fix[WIDTH-1:0];
                            end
                        end
                    end
                end
                default: begin
                    // FIX and DIVZ: writeback already committed, return to idle
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_sequencer.sv
// Directed testbench for mul_div_sequencer.
module tb_mul_div_sequencer;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] src_a;
    logic [W-1:0] src_b;
    logic         flush;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int checks = 0;
    int errors = 0;

    // Results of the last run_op
    int           r_lat;
    int           r_busy;
    logic [W-1:0] r_hi;
    logic [W-1:0] r_lo;

    mul_div_sequencer #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .src_a (src_a),
        .src_b (src_b),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    // Launch one op and count negedges until done (bounded)
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        bit got;
        @(negedge clk);
        start = 1'b1; op = o; src_a = a; src_b = b;
        @(posedge clk);
        #1 start = 1'b0;
        r_lat = 0; r_busy = 0; got = 0;
        while (!got && r_lat < 100) begin
            @(negedge clk);
            r_lat++;
            if (busy) r_busy++;
            if (done) begin
                got = 1;
                r_hi = hi;
                r_lo = lo;
            end
        end
        if (!got) begin
            r_lat = -1;
            r_hi = 'x;
            r_lo = 'x;
        end
        $display("op=%0d a=%h b=%h lat=%0d busy=%0d hi=%h lo=%h", o, a, b, r_lat, r_busy, r_hi, r_lo);
    endtask

    task automatic check_result(input string name, input int lat,
                                input logic [W-1:0] ehi, input logic [W-1:0] elo);
        checks++;
        if (r_lat !== lat) begin errors++; $display("FAIL %s latency got %0d want %0d", name, r_lat, lat); end
        checks++;
        if (r_hi !== ehi) begin errors++; $display("FAIL %s hi got %h want %h", name, r_hi, ehi); end
        checks++;
        if (r_lo !== elo) begin errors++; $display("FAIL %s lo got %h want %h", name, r_lo, elo); end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, done, hi, lo} !== {2'b00, {2*W{1'b0}}}) begin
            errors++;
            $display("FAIL reset busy=%b done=%b hi=%h lo=%h want all zero", busy, done, hi, lo);
        end
        $display("reset busy=%b done=%b hi=%h lo=%h", busy, done, hi, lo);
        reset = 1'b0;
    endtask

    task automatic test_multu();
        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
        check_result("multu_max", 33, 32'hFFFFFFFE, 32'h00000001);
        checks++;
        if (r_busy !== 33) begin errors++; $display("FAIL multu_busy got %0d want 33", r_busy); end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_signed();
        run_op(2'b00, -32'sd7, 32'd3);
        check_result("mult_neg", 33, 32'hFFFFFFFF, 32'hFFFFFFEB);
        run_op(2'b10, -32'sd7, 32'd2);
        check_result("div_neg", 33, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op(2'b11, 32'd100, 32'd7);
        check_result("divu", 33, 32'd2, 32'd14);
        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF);
        check_result("div_ovf", 33, 32'h0, 32'h80000000);
        run_op(2'b00, -32'sd6, -32'sd5);
        check_result("mult_negneg", 33, 32'h0, 32'd30);
    endtask

    task automatic test_divzero();
        run_op(2'b11, 32'd5, 32'd0);
        check_result("divz", 1, 32'd5, 32'hFFFFFFFF);
        checks++;
        if (r_busy !== 1) begin errors++; $display("FAIL divz_busy got %0d want 1", r_busy); end
    endtask

    // Flush at edge start+10: busy drops, no done, hi/lo hold (5 / all ones from divz)
    task automatic test_flush();
        bit saw_done = 0;
        @(negedge clk);
        start = 1'b1; op = 2'b01; src_a = 32'd3; src_b = 32'd5;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %b want 0", busy); end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) saw_done = 1;
        end
        checks++;
        if (saw_done !== 1'b0) begin errors++; $display("FAIL flush_done got pulse want none"); end
        checks++;
        if (hi !== 32'd5 || lo !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL flush_hold hi=%h lo=%h want 00000005 ffffffff", hi, lo);
        end
        $display("flush busy=%b hi=%h lo=%h", busy, hi, lo);
    endtask

    task automatic test_flush_start_idle();
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = 2'b01; src_a = 32'd2; src_b = 32'd2;
        @(posedge clk);
        #1 start = 1'b0; flush = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL flush_start busy got %b want 0", busy); end
        $display("flush+start busy=%b", busy);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        start = 1'b1; op = 2'b11; src_a = 32'd100; src_b = 32'd7;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (19) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || hi !== '0 || lo !== '0) begin
            errors++;
            $display("FAIL reset_mid busy=%b hi=%h lo=%h want 0 0 0", busy, hi, lo);
        end
        $display("reset_mid busy=%b hi=%h lo=%h", busy, hi, lo);
    endtask

    // A second start mid-RUN with different operands must be ignored
    task automatic test_start_ignored();
        bit got = 0;
        int n = 0;
        @(negedge clk);
        start = 1'b1; op = 2'b01; src_a = 32'd6; src_b = 32'd7;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #1 start = 1'b1; op = 2'b10; src_a = 32'd99; src_b = 32'd0;
        @(posedge clk);
        #1 start = 1'b0;
        n = 6;
        while (!got && n < 100) begin
            @(negedge clk);
            n++;
            if (done) got = 1;
        end
        checks++;
        if (n !== 33) begin errors++; $display("FAIL restart_lat got %0d want 33", n); end
        checks++;
        if (hi !== 32'd0 || lo !== 32'd42) begin
            errors++;
            $display("FAIL restart_result hi=%h lo=%h want 00000000 0000002a", hi, lo);
        end
        $display("restart lat=%0d hi=%h lo=%h", n, hi, lo);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0; flush = 1'b0;
        test_reset();
        test_multu();
        test_signed();
        test_divzero();
        test_flush();
        test_flush_start_idle();
        test_reset_mid();
        test_start_ignored();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
